// File: rtl/pipe_stage_reg_pkg.sv
// ============================================================================
// pipe_stage_reg_pkg : payload layout, occupancy states and slot controls
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_stage_reg_pkg;

    // Common payload fields shared by the E->M and M->W stage payloads
    localparam int PC_LSB       = 0;
    localparam int PC_W         = 32;
    localparam int ALU_OUT_LSB  = PC_LSB + PC_W;
    localparam int ALU_OUT_W    = 32;
    localparam int RD2_LSB      = ALU_OUT_LSB + ALU_OUT_W;
    localparam int RD2_W        = 32;
    localparam int A3_LSB       = RD2_LSB + RD2_W;
    localparam int A3_W         = 5;
    localparam int HI_LSB       = A3_LSB + A3_W;
    localparam int HI_W         = 32;
    localparam int LO_LSB       = HI_LSB + HI_W;
    localparam int LO_W         = 32;
    localparam int EXC_CODE_LSB = LO_LSB + LO_W;
    localparam int EXC_CODE_W   = 5;
    localparam int BD_LSB       = EXC_CODE_LSB + EXC_CODE_W;
    localparam int BD_W         = 1;
    localparam int CTRL_LSB     = BD_LSB + BD_W;
    localparam int CTRL_W       = 13;

    // EM carries everything; MW drops rd2 once the memory write has happened
    localparam int EM_PAYLOAD_W = CTRL_LSB + CTRL_W;
    localparam int MW_PAYLOAD_W = EM_PAYLOAD_W - RD2_W;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic load;
        logic clr;
        logic kill;
    } slot_ctrl_t;

    function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
        logic [1:0] n;
        n = {1'b0, main_v} + {1'b0, skid_v};
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// pipe_slot : one valid bit plus DW-bit payload with load / clear / kill
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DW          = 160,
    parameter int CLR_PAYLOAD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  slot_ctrl_t    ctrl,
    input  logic [DW-1:0] d,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_d, valid_q;
    logic [DW-1:0] data_d,  data_q;

    // kill dominates load; clr drops only the valid bit
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ctrl.kill) begin
            valid_d = 1'b0;
            if (CLR_PAYLOAD != 0) begin
                data_d = '0;
            end
        end else if (ctrl.load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (ctrl.clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    generate
        if (CLR_PAYLOAD != 0) begin : g_clr_payload
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end
        end else begin : g_keep_payload
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end
    endgenerate

    assign valid = valid_q;
    assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : valid/ready pipeline stage register, optional skid slot
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DW          = 160,
    parameter int SKID        = 0,
    parameter int CLR_PAYLOAD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    logic          accept;
    logic          consume;
    slot_ctrl_t    main_ctrl;
    logic          main_valid;
    logic [DW-1:0] main_data;
    logic [DW-1:0] main_din;

    assign accept  = in_valid & in_ready & ~flush;
    assign consume = out_valid & out_ready;

    pipe_slot #(
        .DW          (DW),
        .CLR_PAYLOAD (CLR_PAYLOAD)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (main_ctrl),
        .d     (main_din),
        .valid (main_valid),
        .data  (main_data)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;

    generate
        if (SKID == 0) begin : g_single
            always_comb begin
                main_ctrl      = '0;
                main_ctrl.kill = flush;
                main_ctrl.load = accept;
                main_ctrl.clr  = consume & ~accept;
            end

            assign main_din = in_data;
            assign in_ready = ~main_valid | out_ready;
            assign occ      = occ_of(main_valid, 1'b0);
        end else begin : g_skid
            slot_ctrl_t    skid_ctrl;
            logic          skid_valid;
            logic [DW-1:0] skid_data;
            logic [1:0]    state;

            pipe_slot #(
                .DW          (DW),
                .CLR_PAYLOAD (CLR_PAYLOAD)
            ) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .ctrl  (skid_ctrl),
                .d     (in_data),
                .valid (skid_valid),
                .data  (skid_data)
            );

            // skid is only ever occupied behind a valid main entry
            assign state = occ_of(main_valid, skid_valid);

            always_comb begin
                main_ctrl      = '0;
                skid_ctrl      = '0;
                main_ctrl.kill = flush;
                skid_ctrl.kill = flush;
                case (state)
                    OCC_EMPTY: begin
                        main_ctrl.load = accept;
                    end
                    OCC_ONE: begin
                        if (accept & consume) begin
                            main_ctrl.load = 1'b1;
                        end else if (accept) begin
                            skid_ctrl.load = 1'b1;
                        end else if (consume) begin
                            main_ctrl.clr = 1'b1;
                        end
                    end
                    OCC_FULL: begin
                        if (consume) begin
                            main_ctrl.load = 1'b1;
                            skid_ctrl.clr  = 1'b1;
                        end
                    end
                    default: begin
                        main_ctrl.clr = 1'b1;
                        skid_ctrl.clr = 1'b1;
                    end
                endcase
            end

            assign main_din = (state == OCC_FULL) ? skid_data : in_data;
            assign in_ready = ~skid_valid;
            assign occ      = state;
        end
    endgenerate

endmodule

`default_nettype wire
